// File: rtl/iso14443a_pkg.sv
// Shared definitions for the ISO 14443-A PCD->PICC deframer:
// FSM state encoding, CRC_A constants and the short-frame bit count.
package iso14443a_pkg;

    // Deframer states; SHORT is the one-cycle emit slot for 7-bit frames
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_SHORT  = 3'd4,
        ST_ERROR  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // CRC_A polynomial x^16+x^12+x^5+1 in bit-reflected form (0x1021 reversed)
    localparam logic [15:0] CRC_A_POLY = 16'h8408;
    localparam logic [15:0] CRC_A_INIT = 16'h6363;

    // REQA/WUPA are sent as a single 7-bit frame without parity
    localparam int SHORT_FRAME_BITS = 7;

endpackage

// File: rtl/iso14443a_deframer_crc_a_byte.sv
// Byte-wide CRC_A next-state (reflected, LSB first), purely combinational.
module crc_a_byte
    import iso14443a_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    // Fold the byte in, then run eight reflected shift/xor steps
    always_comb begin
        w_crc = i_crc ^ {8'h00, i_data};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0]) begin
                w_crc = (w_crc >> 1) ^ CRC_A_POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/iso14443a_deframer.sv
// ISO 14443-A PCD->PICC deframer: SOF detect, LSB-first byte assembly,
// odd parity check, short-frame (REQA/WUPA) detection and frame error flags.
// Optional CRC_A residue check is built when DEFRAMER_CRC_EN is defined;
// otherwise out_crc_ok is tied low.
module iso14443a_deframer
    import iso14443a_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_enable,
    input  logic             in_bit_strobe,
    input  logic             in_data,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    output logic             out_frame_done,
    output logic             out_short,
    output logic             out_parity_err,
    output logic             out_frame_err,
    output logic [CNT_W-1:0] out_nbytes,
    output logic             out_crc_ok,
    output logic             out_busy
);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_outByte;
    logic             r_valid;
    logic             r_short;
    logic             r_parErr;
    logic             r_frameErr;
    logic [CNT_W-1:0] r_nbytes;
    logic             w_full;
    logic             w_parityOk;
    logic             w_shortEof;

    assign w_full     = (r_nbytes == CNT_W'(MAX_BYTES));
    assign w_parityOk = (in_data == ~^r_shift);
    assign w_shortEof = (r_nbytes == '0) && (r_bitCnt == 3'(SHORT_FRAME_BITS));

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and frame status outputs; EOF always wins over a strobe
    always_comb begin
        w_next         = r_state;
        out_frame_done = 1'b0;
        out_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_enable) w_next = ST_SOF;
            end
            ST_SOF: begin
                if (!in_enable) begin
                    w_next = ST_IDLE;
                end else if (in_bit_strobe && !in_data) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                out_busy = 1'b1;
                if (!in_enable) begin
                    w_next = (r_bitCnt != 3'd0 && w_shortEof) ? ST_SHORT : ST_DONE;
                end else if (in_bit_strobe && r_bitCnt == 3'd7) begin
                    w_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                out_busy = 1'b1;
                if (!in_enable) begin
                    w_next = ST_DONE;
                end else if (in_bit_strobe) begin
                    w_next = w_full ? ST_ERROR : ST_DATA;
                end
            end
            ST_SHORT: begin
                out_busy = 1'b1;
                w_next   = ST_DONE;
            end
            ST_ERROR: begin
                out_busy = 1'b1;
                if (!in_enable) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_frame_done = 1'b1;
                w_next         = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef DEFRAMER_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crcNext;

    crc_a_byte u_crc (
        .i_crc  (r_crc),
        .i_data (r_shift),
        .o_crc  (w_crcNext)
    );

    // Running CRC_A over every emitted byte, restarted when a frame opens
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC_A_INIT;
        end else if (r_state == ST_IDLE && in_enable) begin
            r_crc <= CRC_A_INIT;
        end else if (r_state == ST_PARITY && in_enable && in_bit_strobe && !w_full) begin
            r_crc <= w_crcNext;
        end
    end

    // Data plus appended CRC leaves a zero residue; needs at least one data byte + 2 CRC bytes
    assign out_crc_ok = (r_nbytes >= CNT_W'(3)) && (r_crc == 16'h0000);
`else
    assign out_crc_ok = 1'b0;
`endif

    // Bit/byte assembly, output byte register and sticky per-frame flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_outByte  <= '0;
            r_valid    <= 1'b0;
            r_short    <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_nbytes   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_enable) begin
                        r_bitCnt   <= '0;
                        r_shift    <= '0;
                        r_short    <= 1'b0;
                        r_parErr   <= 1'b0;
                        r_frameErr <= 1'b0;
                        r_nbytes   <= '0;
                    end
                end
                ST_DATA: begin
                    if (!in_enable) begin
                        if (r_bitCnt != 3'd0) begin
                            if (w_shortEof) begin
                                r_outByte <= {1'b0, r_shift[7:1]};
                                r_valid   <= 1'b1;
                                r_short   <= 1'b1;
                            end else begin
                                r_frameErr <= 1'b1;
                            end
                        end
                    end else if (in_bit_strobe) begin
                        r_shift  <= {in_data, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (!in_enable) begin
                        r_frameErr <= 1'b1;
                    end else if (in_bit_strobe) begin
                        if (w_full) begin
                            r_frameErr <= 1'b1;
                        end else begin
                            if (!w_parityOk) r_parErr <= 1'b1;
                            r_outByte <= r_shift;
                            r_valid   <= 1'b1;
                            r_nbytes  <= r_nbytes + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_byte       = r_outByte;
    assign out_valid      = r_valid;
    assign out_short      = r_short;
    assign out_parity_err = r_parErr;
    assign out_frame_err  = r_frameErr;
    assign out_nbytes     = r_nbytes;

endmodule

// File: tb/tb_iso14443a_deframer.sv
// Directed self-checking bench for iso14443a_deframer. A second instance
// with MAX_BYTES=2 shares the stimulus and is used for the overflow case.
// CRC residue cases are compiled in when DEFRAMER_CRC_EN is defined.
module tb_iso14443a_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_enable = 1'b0;
    logic       in_bit_strobe = 1'b0;
    logic       in_data = 1'b0;

    logic [7:0] outByte, smallOutByte;
    logic       outValid, smallOutValid;
    logic       outFrameDone, smallOutFrameDone;
    logic       outShort, smallOutShort;
    logic       outParityErr, smallOutParityErr;
    logic       outFrameErr, smallOutFrameErr;
    logic [6:0] outNbytes, smallOutNbytes;
    logic       outCrcOk, smallOutCrcOk;
    logic       outBusy, smallOutBusy;

    int checkCnt = 0;
    int errCnt   = 0;

    int validCnt = 0;
    int doneCnt = 0;
    int smallValidCnt = 0;
    int smallDoneCnt = 0;
    logic [7:0] byteLog [0:63];

    logic validAfter;
    logic smallValidAfter;

    iso14443a_deframer dut (
        .clk            (clk),
        .rst            (rst),
        .in_enable      (in_enable),
        .in_bit_strobe  (in_bit_strobe),
        .in_data        (in_data),
        .out_byte       (outByte),
        .out_valid      (outValid),
        .out_frame_done (outFrameDone),
        .out_short      (outShort),
        .out_parity_err (outParityErr),
        .out_frame_err  (outFrameErr),
        .out_nbytes     (outNbytes),
        .out_crc_ok     (outCrcOk),
        .out_busy       (outBusy)
    );

    iso14443a_deframer #(.MAX_BYTES(2), .CNT_W(7)) dutSmall (
        .clk            (clk),
        .rst            (rst),
        .in_enable      (in_enable),
        .in_bit_strobe  (in_bit_strobe),
        .in_data        (in_data),
        .out_byte       (smallOutByte),
        .out_valid      (smallOutValid),
        .out_frame_done (smallOutFrameDone),
        .out_short      (smallOutShort),
        .out_parity_err (smallOutParityErr),
        .out_frame_err  (smallOutFrameErr),
        .out_nbytes     (smallOutNbytes),
        .out_crc_ok     (smallOutCrcOk),
        .out_busy       (smallOutBusy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Pulse counters and byte log, sampled away from the active edge
    always @(negedge clk) begin
        if (outValid) begin
            byteLog[validCnt % 64] = outByte;
            validCnt++;
        end
        if (outFrameDone) doneCnt++;
        if (smallOutValid) smallValidCnt++;
        if (smallOutFrameDone) smallDoneCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        in_bit_strobe = 1'b1;
        in_data       = b;
        @(negedge clk);
        in_bit_strobe   = 1'b0;
        in_data         = 1'b0;
        validAfter      = outValid;
        smallValidAfter = smallOutValid;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic flipParity);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit((~^b) ^ flipParity);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        in_enable = 1'b1;
        repeat (2) @(negedge clk);
        sendBit(1'b1);
        sendBit(1'b0);
    endtask

    task automatic endFrame(output logic seenMain, output logic seenSmall);
        seenMain  = 1'b0;
        seenSmall = 1'b0;
        @(negedge clk);
        in_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outFrameDone) seenMain = 1'b1;
            if (smallOutFrameDone) seenSmall = 1'b1;
        end
    endtask

    logic seenMain, seenSmall;
    int   base, smallBase, doneBase, smallDoneBase;
    logic [7:0] reqa;

    initial begin
        reqa = 8'h26;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_byte",   32'(outByte), 32'h0);
        checkOutput("rst_valid",  32'(outValid), 32'h0);
        checkOutput("rst_done",   32'(outFrameDone), 32'h0);
        checkOutput("rst_nbytes", 32'(outNbytes), 32'h0);
        checkOutput("rst_busy",   32'(outBusy), 32'h0);
        checkOutput("rst_crc",    32'(outCrcOk), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Window opens and closes before any SOF bit: no frame_done
        doneBase = doneCnt;
        @(negedge clk);
        in_enable = 1'b1;
        repeat (3) @(negedge clk);
        sendBit(1'b1);
        in_enable = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("nosof_done", 32'(doneCnt - doneBase), 32'h0);
        checkOutput("nosof_busy", 32'(outBusy), 32'h0);

        // REQA: 7 bits, EOF arrives together with a strobe that must be ignored
        applyStimulus();
        checkOutput("reqa_busy", 32'(outBusy), 32'h1);
        for (int i = 0; i < 7; i++) sendBit(reqa[i]);
        @(negedge clk);
        in_enable     = 1'b0;
        in_bit_strobe = 1'b1;
        in_data       = 1'b1;
        @(negedge clk);
        in_bit_strobe = 1'b0;
        in_data       = 1'b0;
        checkOutput("reqa_valid",  32'(outValid), 32'h1);
        checkOutput("reqa_byte",   32'(outByte), 32'h26);
        checkOutput("reqa_short",  32'(outShort), 32'h1);
        checkOutput("reqa_nbytes", 32'(outNbytes), 32'h0);
        checkOutput("reqa_done0",  32'(outFrameDone), 32'h0);
        @(negedge clk);
        checkOutput("reqa_valid1", 32'(outValid), 32'h0);
        checkOutput("reqa_done1",  32'(outFrameDone), 32'h1);
        checkOutput("reqa_crc",    32'(outCrcOk), 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("reqa_hold_short", 32'(outShort), 32'h1);

        // ANTICOLL 93 20, clean frame; small instance reaches exactly its limit
        base = validCnt;
        smallBase = smallValidCnt;
        applyStimulus();
        checkOutput("anti_short_cleared", 32'(outShort), 32'h0);
        sendByte(8'h93, 1'b0);
        checkOutput("anti_latency", 32'(validAfter), 32'h1);
        sendByte(8'h20, 1'b0);
        endFrame(seenMain, seenSmall);
        repeat (2) @(negedge clk);
        checkOutput("anti_done",    32'(seenMain), 32'h1);
        checkOutput("anti_nvalid",  32'(validCnt - base), 32'h2);
        checkOutput("anti_byte0",   32'(byteLog[base % 64]), 32'h93);
        checkOutput("anti_byte1",   32'(byteLog[(base + 1) % 64]), 32'h20);
        checkOutput("anti_nbytes",  32'(outNbytes), 32'h2);
        checkOutput("anti_parerr",  32'(outParityErr), 32'h0);
        checkOutput("anti_frmerr",  32'(outFrameErr), 32'h0);
        checkOutput("anti_short",   32'(outShort), 32'h0);
        checkOutput("anti_last",    32'(outByte), 32'h20);
        checkOutput("small_atmax_nvalid", 32'(smallValidCnt - smallBase), 32'h2);
        checkOutput("small_atmax_frmerr", 32'(smallOutFrameErr), 32'h0);

        // Bad parity on 0x93: byte still emitted, sticky parity error
        base = validCnt;
        applyStimulus();
        sendByte(8'h93, 1'b1);
        checkOutput("par_latency", 32'(validAfter), 32'h1);
        endFrame(seenMain, seenSmall);
        repeat (2) @(negedge clk);
        checkOutput("par_done",   32'(seenMain), 32'h1);
        checkOutput("par_nvalid", 32'(validCnt - base), 32'h1);
        checkOutput("par_byte",   32'(byteLog[base % 64]), 32'h93);
        checkOutput("par_parerr", 32'(outParityErr), 32'h1);
        checkOutput("par_frmerr", 32'(outFrameErr), 32'h0);

        // Partial frame: one byte plus four bits
        applyStimulus();
        checkOutput("part_parerr_cleared", 32'(outParityErr), 32'h0);
        sendByte(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        endFrame(seenMain, seenSmall);
        checkOutput("part_done",   32'(seenMain), 32'h1);
        checkOutput("part_frmerr", 32'(outFrameErr), 32'h1);
        checkOutput("part_nbytes", 32'(outNbytes), 32'h1);
        checkOutput("part_short",  32'(outShort), 32'h0);

        // Overflow on the MAX_BYTES=2 instance, trailing strobes ignored
        smallBase = smallValidCnt;
        applyStimulus();
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h33, 1'b0);
        checkOutput("ovf_no_valid", 32'(smallValidAfter), 32'h0);
        smallDoneBase = smallDoneCnt;
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        checkOutput("ovf_busy_trailing", 32'(smallOutBusy), 32'h1);
        checkOutput("ovf_no_early_done", 32'(smallDoneCnt - smallDoneBase), 32'h0);
        endFrame(seenMain, seenSmall);
        repeat (2) @(negedge clk);
        checkOutput("ovf_done",   32'(seenSmall), 32'h1);
        checkOutput("ovf_nvalid", 32'(smallValidCnt - smallBase), 32'h2);
        checkOutput("ovf_frmerr", 32'(smallOutFrameErr), 32'h1);
        checkOutput("ovf_nbytes", 32'(smallOutNbytes), 32'h2);
        checkOutput("ovf_main_nbytes", 32'(outNbytes), 32'h3);

        // HLTA 50 00 57 CD
        applyStimulus();
        sendByte(8'h50, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h57, 1'b0);
        sendByte(8'hCD, 1'b0);
        endFrame(seenMain, seenSmall);
        checkOutput("hlta_done",   32'(seenMain), 32'h1);
        checkOutput("hlta_nbytes", 32'(outNbytes), 32'h4);
`ifdef DEFRAMER_CRC_EN
        checkOutput("hlta_crc_ok", 32'(outCrcOk), 32'h1);
        applyStimulus();
        sendByte(8'h50, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h57, 1'b0);
        sendByte(8'hCE, 1'b0);
        endFrame(seenMain, seenSmall);
        checkOutput("hlta_bad_done", 32'(seenMain), 32'h1);
        checkOutput("hlta_bad_crc",  32'(outCrcOk), 32'h0);
`else
        checkOutput("hlta_crc_tied", 32'(outCrcOk), 32'h0);
`endif

        // Reset in the middle of a frame
        doneBase = doneCnt;
        applyStimulus();
        sendByte(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) sendBit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mrst_byte",   32'(outByte), 32'h0);
        checkOutput("mrst_nbytes", 32'(outNbytes), 32'h0);
        checkOutput("mrst_busy",   32'(outBusy), 32'h0);
        checkOutput("mrst_valid",  32'(outValid), 32'h0);
        checkOutput("mrst_flags",  32'({outShort, outParityErr, outFrameErr, outCrcOk}), 32'h0);
        in_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mrst_no_done", 32'(doneCnt - doneBase), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
